// File: rtl/led_cursor_ctrl.sv
// led_cursor_ctrl: single-LED cursor over N_CH colour banks of N_LEDS LEDs.
// Four push buttons are synchronised, debounced and edge-detected; right/left
// move the cursor within a bank with wrap-around, next/prev cycle the bank.
// Optional feature macro: AUTO_REPEAT_EN (hold-to-repeat on right/left).
//
// state  | meaning
// pos_q  | cursor index inside the current bank
// ch_q   | current colour bank (0=red, 1=green, 2=blue)
// evt_q  | pos_q or ch_q changed on the last edge
module led_cursor_ctrl #(
    parameter int N_LEDS          = 4,
    parameter int N_CH            = 3,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 250
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 button,
    output logic [N_CH*N_LEDS-1:0]     led,
    output logic [$clog2(N_LEDS)-1:0]  pos,
    output logic [$clog2(N_CH)-1:0]    ch,
    output logic                       evt
);
    localparam int PW  = $clog2(N_LEDS);
    localparam int CW  = $clog2(N_CH);
    localparam int DCW = $clog2(DEBOUNCE_CYCLES);

    // Reject configurations the cursor and timers cannot represent.
    if (N_LEDS < 2 || N_CH < 2 || DEBOUNCE_CYCLES < 2 ||
        REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("led_cursor_ctrl: illegal parameter value");
    end

    logic [3:0]     sync1_q, sync2_q, stable_q;
    logic [DCW-1:0] deb_cnt_q [4];
    logic [3:0]     press;
    logic [1:0]     rep;          // [0]=right repeat, [1]=left repeat

    logic [PW-1:0]  pos_q, pos_d;
    logic [CW-1:0]  ch_q, ch_d;
    logic           evt_q, evt_d;

    // Two-flop synchroniser and per-button debounce counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] != stable_q[i]) begin
                    if (deb_cnt_q[i] == DCW'(DEBOUNCE_CYCLES - 1)) begin
                        stable_q[i]  <= sync2_q[i];
                        deb_cnt_q[i] <= '0;
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                    end
                end else begin
                    deb_cnt_q[i] <= '0;
                end
            end
        end
    end

    // Press pulse is raised in the cycle whose edge accepts a new high level,
    // so the cursor moves on the same edge the stable level rises.
    always_comb begin
        press = '0;
        for (int i = 0; i < 4; i++) begin
            press[i] = sync2_q[i] && !stable_q[i] &&
                       (deb_cnt_q[i] == DCW'(DEBOUNCE_CYCLES - 1));
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(HMAX + 1);

    logic [HW-1:0] hold_q [2];

    // Down-counting hold timers for right (0) and left (1); reload on each repeat.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q[0] <= '0;
            hold_q[1] <= '0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (press[j*3]) begin
                    hold_q[j] <= HW'(REPEAT_DELAY - 1);
                end else if (stable_q[j*3]) begin
                    if (hold_q[j] == '0) hold_q[j] <= HW'(REPEAT_PERIOD - 1);
                    else                 hold_q[j] <= hold_q[j] - 1'b1;
                end else begin
                    hold_q[j] <= '0;
                end
            end
        end
    end

    // Repeat fires when a held button's timer reaches terminal count.
    always_comb begin
        rep = '0;
        for (int j = 0; j < 2; j++) begin
            rep[j] = stable_q[j*3] && !press[j*3] && (hold_q[j] == '0);
        end
    end
`else
    assign rep = '0;
`endif

    // Next cursor position/bank; opposing requests in one cycle cancel.
    always_comb begin
        logic mv_r, mv_l;
        mv_r  = press[0] | rep[0];
        mv_l  = press[3] | rep[1];
        pos_d = pos_q;
        ch_d  = ch_q;
        if (mv_r && !mv_l) begin
            pos_d = (pos_q == '0) ? PW'(N_LEDS - 1) : pos_q - 1'b1;
        end else if (mv_l && !mv_r) begin
            pos_d = (pos_q == PW'(N_LEDS - 1)) ? '0 : pos_q + 1'b1;
        end
        if (press[2] && !press[1]) begin
            ch_d = (ch_q == CW'(N_CH - 1)) ? '0 : ch_q + 1'b1;
        end else if (press[1] && !press[2]) begin
            ch_d = (ch_q == '0) ? CW'(N_CH - 1) : ch_q - 1'b1;
        end
        evt_d = (pos_d != pos_q) || (ch_d != ch_q);
    end

    // Cursor state and change pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q <= '0;
            ch_q  <= '0;
            evt_q <= 1'b0;
        end else begin
            pos_q <= pos_d;
            ch_q  <= ch_d;
            evt_q <= evt_d;
        end
    end

    // One-hot LED decode from the registered cursor.
    always_comb begin
        led = '0;
        for (int b = 0; b < N_CH; b++) begin
            for (int l = 0; l < N_LEDS; l++) begin
                led[b*N_LEDS + l] = (ch_q == CW'(b)) && (pos_q == PW'(l));
            end
        end
    end

    assign pos = pos_q;
    assign ch  = ch_q;
    assign evt = evt_q;
endmodule

// File: tb/tb_led_cursor_ctrl.sv
// Directed bench for led_cursor_ctrl with N_LEDS=4, N_CH=3, DEBOUNCE_CYCLES=4.
module tb_led_cursor_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  button = 4'b0000;
    logic [11:0] led;
    logic [1:0]  pos;
    logic [1:0]  ch;
    logic        evt;

    int total = 0;
    int bad = 0;
    int n_evt = 0;
    int oh_bad = 0;
    int first_k;

    led_cursor_ctrl #(
        .N_LEDS(4), .N_CH(3), .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk), .rst(rst), .button(button),
        .led(led), .pos(pos), .ch(ch), .evt(evt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (evt) n_evt++;
        if ($countones(led) != 1) oh_bad++;
    endtask

    task automatic press(input logic [3:0] b);
        button = b;
        repeat (6) tick();
        button = 4'b0000;
        repeat (8) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

`ifdef AUTO_REPEAT_EN
    int ev_n;
    int ev_t [8];
    int exp_t [5] = '{6, 26, 31, 36, 41};
`endif

    initial begin
        // reset state
        repeat (3) tick();
        check("rst_led", 32'(led), 32'h001);
        check("rst_pos", 32'(pos), 0);
        check("rst_ch",  32'(ch),  0);
        check("rst_evt", 32'(evt), 0);

        // right held from reset release: single move on cycle 6
        rst = 1'b0;
        button = 4'b0001;
        n_evt = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 5) check("r_early_evt", 32'(evt), 0);
            if (k == 6) begin
                check("r_evt", 32'(evt), 1);
                check("r_pos", 32'(pos), 3);
                check("r_led", 32'(led), 32'h008);
            end
        end
        check("r_nevt", 32'(n_evt), 1);
        button = 4'b0000;
        repeat (8) tick();

        // left wrap 0,1,2,3,0
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            press(4'b1000);
            check("l_pos", 32'(pos), 32'(i % 4));
        end
        check("l_led", 32'(led), 32'h001);

        // bank cycling at pos=2
        press(4'b1000);
        press(4'b1000);
        check("b_pos", 32'(pos), 2);
        press(4'b0100);
        check("b_next_ch", 32'(ch), 1);
        check("b_next_led", 32'(led), 32'h040);
        press(4'b0010);
        check("b_prev_ch", 32'(ch), 0);
        check("b_prev_led", 32'(led), 32'h004);
        press(4'b0010);
        check("b_wrap_ch", 32'(ch), 2);
        check("b_wrap_led", 32'(led), 32'h400);

        // glitching right never debounces
        n_evt = 0;
        for (int i = 0; i < 20; i++) begin
            button[0] = ~button[0];
            tick();
        end
        button = 4'b0000;
        repeat (8) tick();
        check("g_nevt", 32'(n_evt), 0);
        check("g_pos", 32'(pos), 2);

        // right and left together cancel
        n_evt = 0;
        press(4'b1001);
        check("c_nevt", 32'(n_evt), 0);
        check("c_pos", 32'(pos), 2);
        check("c_ch", 32'(ch), 2);

        // reset mid-debounce with left held through release
        do_reset();
        button = 4'b1000;
        repeat (3) tick();
        rst = 1'b1;
        n_evt = 0;
        repeat (4) tick();
        check("m_rst_nevt", 32'(n_evt), 0);
        check("m_rst_pos", 32'(pos), 0);
        rst = 1'b0;
        first_k = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (evt && first_k == 0) first_k = k;
        end
        check("m_first", 32'(first_k), 6);
        check("m_nevt", 32'(n_evt), 1);
        check("m_pos", 32'(pos), 1);
        check("m_led", 32'(led), 32'h002);
        button = 4'b0000;
        repeat (8) tick();

`ifdef AUTO_REPEAT_EN
        // held left: press move then repeats at +20, +25, +30, +35
        do_reset();
        button = 4'b1000;
        ev_n = 0;
        for (int k = 1; k <= 44; k++) begin
            tick();
            if (evt) begin
                if (ev_n < 8) ev_t[ev_n] = k;
                ev_n++;
            end
        end
        check("a_count", 32'(ev_n), 5);
        for (int i = 0; i < 5; i++) check("a_time", 32'(ev_t[i]), 32'(exp_t[i]));
        check("a_pos", 32'(pos), 1);
        button = 4'b0000;
        repeat (10) tick();
`endif

        check("onehot", 32'(oh_bad), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
